// File: rtl/sdram_fb_req.sv
// Frame-buffer burst requester: alternates write/read SDRAM bursts and tracks frame addresses.
// Optional macro FB_REQ_TIMEOUT_EN adds an ack-timeout counter and a sticky timeout_err flag.
module sdram_fb_req #(
  parameter int BURST_LEN   = 64,
  parameter int FRAME_WORDS = 2073600,
  parameter int TIMEOUT     = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic [10:0] wr_level,
  input  logic [10:0] rd_space,
  input  logic        rd_enable,
  input  logic        wr_vsync,
  input  logic        rd_vsync,
  input  logic        sdram_wr_ack,
  input  logic        sdram_rd_ack,
  output logic        sdram_wr_req,
  output logic [20:0] sdram_wr_addr,
  output logic [9:0]  wr_burst_len,
  output logic        sdram_rd_req,
  output logic [20:0] sdram_rd_addr,
  output logic [9:0]  rd_burst_len,
  output logic        busy,
  output logic        timeout_err
);

  if (BURST_LEN < 1 || BURST_LEN > 512 || FRAME_WORDS < BURST_LEN ||
      FRAME_WORDS > 2097152 || TIMEOUT < 1) begin : gBadParams
    $error("sdram_fb_req: parameter out of range");
  end

  localparam logic [9:0] INIT_LEN = (BURST_LEN < FRAME_WORDS) ? 10'(BURST_LEN) : 10'(FRAME_WORDS);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST} state_t;

  // Last burst of a frame is clipped to the words remaining before the frame end.
  function automatic logic [9:0] lenFor(input logic [20:0] addr);
    logic [21:0] remain;
    remain = 22'(FRAME_WORDS) - {1'b0, addr};
    if (remain >= 22'(BURST_LEN)) return 10'(BURST_LEN);
    return remain[9:0];
  endfunction

  function automatic logic [20:0] nextAddr(input logic [20:0] addr, input logic [9:0] len);
    logic [21:0] sum;
    sum = {1'b0, addr} + {12'd0, len};
    return (sum == 22'(FRAME_WORDS)) ? 21'd0 : sum[20:0];
  endfunction

  state_t      state_q, state_d;
  logic [20:0] wrAddr_q, wrAddr_d, rdAddr_q, rdAddr_d;
  logic [9:0]  wrLen_q, wrLen_d, rdLen_q, rdLen_d;
  logic        wrReq_q, wrReq_d, rdReq_q, rdReq_d;
  logic        wrPend_q, wrPend_d, rdPend_q, rdPend_d;
  logic        lastWr_q, lastWr_d;
  logic        busy_q, busy_d;
  logic        wrAckPrev_q, rdAckPrev_q;
  logic        wrActive, rdActive, wrZero, rdZero, wrElig, rdElig;

`ifdef FB_REQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic            timeoutErr_q, timeoutErr_d;
`endif

  always_comb begin
    state_d  = state_q;
    wrAddr_d = wrAddr_q;
    rdAddr_d = rdAddr_q;
    wrPend_d = wrPend_q;
    rdPend_d = rdPend_q;
    lastWr_d = lastWr_q;
`ifdef FB_REQ_TIMEOUT_EN
    timeoutErr_d = timeoutErr_q;
`endif

    wrActive = (state_q == WR_REQ) || (state_q == WR_BURST);
    rdActive = (state_q == RD_REQ) || (state_q == RD_BURST);
    // A side with a frame restart due must rewind before it may request again.
    wrZero   = !wrActive && (wr_vsync || wrPend_q);
    rdZero   = !rdActive && (rd_vsync || rdPend_q);
    wrElig   = (wr_level >= {1'b0, wrLen_q}) && !wrZero;
    rdElig   = rd_enable && (rd_space >= {1'b0, rdLen_q}) && !rdZero;

    if (wrZero) begin
      wrAddr_d = '0;
      wrPend_d = 1'b0;
    end else if (wr_vsync) begin
      wrPend_d = 1'b1;
    end
    if (rdZero) begin
      rdAddr_d = '0;
      rdPend_d = 1'b0;
    end else if (rd_vsync) begin
      rdPend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (init_end) begin
          if (wrElig && (!rdElig || !lastWr_q)) begin
            state_d  = WR_REQ;
            lastWr_d = 1'b1;
          end else if (rdElig) begin
            state_d  = RD_REQ;
            lastWr_d = 1'b0;
          end
        end
      end
      WR_REQ: begin
        if (sdram_wr_ack) state_d = WR_BURST;
`ifdef FB_REQ_TIMEOUT_EN
        else if (toCnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d      = IDLE;
          timeoutErr_d = 1'b1;
        end
`endif
      end
      WR_BURST: begin
        if (wrAckPrev_q && !sdram_wr_ack) begin
          state_d  = IDLE;
          wrPend_d = 1'b0;
          wrAddr_d = (wrPend_q || wr_vsync) ? 21'd0 : nextAddr(wrAddr_q, wrLen_q);
        end
      end
      RD_REQ: begin
        if (sdram_rd_ack) state_d = RD_BURST;
`ifdef FB_REQ_TIMEOUT_EN
        else if (toCnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d      = IDLE;
          timeoutErr_d = 1'b1;
        end
`endif
      end
      RD_BURST: begin
        if (rdAckPrev_q && !sdram_rd_ack) begin
          state_d  = IDLE;
          rdPend_d = 1'b0;
          rdAddr_d = (rdPend_q || rd_vsync) ? 21'd0 : nextAddr(rdAddr_q, rdLen_q);
        end
      end
      default: state_d = IDLE;
    endcase

    wrLen_d = lenFor(wrAddr_d);
    rdLen_d = lenFor(rdAddr_d);
    wrReq_d = (state_d == WR_REQ);
    rdReq_d = (state_d == RD_REQ);
    busy_d  = (state_d != IDLE);
`ifdef FB_REQ_TIMEOUT_EN
    toCnt_d = ((state_d == WR_REQ || state_d == RD_REQ) && state_d == state_q) ?
              toCnt_q + TO_W'(1) : '0;
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      wrAddr_q    <= '0;
      rdAddr_q    <= '0;
      wrLen_q     <= INIT_LEN;
      rdLen_q     <= INIT_LEN;
      wrReq_q     <= 1'b0;
      rdReq_q     <= 1'b0;
      wrPend_q    <= 1'b0;
      rdPend_q    <= 1'b0;
      lastWr_q    <= 1'b0;
      busy_q      <= 1'b0;
      wrAckPrev_q <= 1'b0;
      rdAckPrev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrAddr_q    <= wrAddr_d;
      rdAddr_q    <= rdAddr_d;
      wrLen_q     <= wrLen_d;
      rdLen_q     <= rdLen_d;
      wrReq_q     <= wrReq_d;
      rdReq_q     <= rdReq_d;
      wrPend_q    <= wrPend_d;
      rdPend_q    <= rdPend_d;
      lastWr_q    <= lastWr_d;
      busy_q      <= busy_d;
      wrAckPrev_q <= sdram_wr_ack;
      rdAckPrev_q <= sdram_rd_ack;
    end
  end

`ifdef FB_REQ_TIMEOUT_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      toCnt_q      <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      toCnt_q      <= toCnt_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end
  assign timeout_err = timeoutErr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign sdram_wr_req  = wrReq_q;
  assign sdram_wr_addr = wrAddr_q;
  assign wr_burst_len  = wrLen_q;
  assign sdram_rd_req  = rdReq_q;
  assign sdram_rd_addr = rdAddr_q;
  assign rd_burst_len  = rdLen_q;
  assign busy          = busy_q;

endmodule

// File: doc/sdram_fb_req.md
SDRAM_FB_REQ -- requirements
Module: sdram_fb_req

Interface
REQ-001 SHALL have parameter BURST_LEN, default 64, words per full burst (legal range 1..512).
REQ-002 SHALL have parameter FRAME_WORDS, default 2073600, 32-bit words per frame (legal range BURST_LEN..2097152).
REQ-003 SHALL have parameter TIMEOUT, default 255, cycles allowed from req assertion to first ack.
REQ-004 SHALL use one clock and an asynchronous active-low reset; all logic runs on sys_clk, and sys_rst_n (active-low, asynchronous assert) resets it.
REQ-005 SHALL have ports:
 sys_clk  in  1  clock.
 sys_rst_n  in  1  async active-low reset.
 init_end  in  1  SDRAM initialisation complete.
 wr_level  in  11  write-FIFO fill, words.
 rd_space  in  11  read-FIFO free space, words.
 rd_enable  in  1  read side permitted.
 wr_vsync  in  1  one-cycle write frame-start pulse.
 rd_vsync  in  1  one-cycle read frame-start pulse.
 sdram_wr_ack  in  1  controller write data strobe.
 sdram_rd_ack  in  1  controller read data strobe.
 sdram_wr_req  out  1  write burst request.
 sdram_wr_addr  out  21  write burst start word.
 wr_burst_len  out  10  write burst length.
 sdram_rd_req  out  1  read burst request.
 sdram_rd_addr  out  21  read burst start word.
 rd_burst_len  out  10  read burst length.
 busy  out  1  burst in flight.
 timeout_err  out  1  sticky ack-timeout flag.

Function
REQ-006 SHALL run FSM states IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST; all outputs registered.
REQ-007 SHALL hold IDLE while init_end=0; no request before init_end=1.
REQ-008 Write-eligible SHALL be wr_level >= wr_burst_len; read-eligible SHALL be rd_enable=1 and rd_space >= rd_burst_len.
REQ-009 In IDLE with both eligible SHALL serve the side not served last (round-robin, write wins first after reset); single eligible side served directly.
REQ-010 IDLE->WR_REQ SHALL assert sdram_wr_req the next cycle, with address and length stable until the burst ends.
REQ-011 WR_REQ SHALL drop sdram_wr_req the cycle after sdram_wr_ack is sampled 1, then enter WR_BURST; read side symmetric (RD_REQ/RD_BURST).
REQ-012 A burst SHALL end on the ack falling edge (ack 1 previous cycle, 0 now); FSM returns to IDLE that cycle, and the next request is issued no earlier than one cycle later.
REQ-013 On burst end SHALL advance the address by the burst length; when the result equals FRAME_WORDS it SHALL wrap to 0.
REQ-014 Burst length SHALL be min(BURST_LEN, FRAME_WORDS - addr), so the last burst of a frame can be partial; this is recomputed after each address update.
REQ-015 wr_vsync/rd_vsync in IDLE SHALL zero that side's address next cycle; during a burst of that side SHALL be latched pending and applied at burst end, overriding the REQ-013 increment.
REQ-016 Coincident vsync pulses on both sides SHALL be handled independently.
REQ-017 busy SHALL be 1 in all states except IDLE.
REQ-018 An ack of the side not currently requested SHALL be ignored.

Reset
REQ-019 On sys_rst_n=0 SHALL immediately force: state IDLE, both req 0, both addr 0, both burst_len = min(BURST_LEN, FRAME_WORDS), busy 0, timeout_err 0, pending vsyncs cleared, round-robin to write-first.
REQ-020 Reset mid-burst SHALL abandon the burst without completing the address update.

Configuration
REQ-021 With FB_REQ_TIMEOUT_EN defined SHALL count cycles in WR_REQ/RD_REQ; on reaching TIMEOUT without ack SHALL drop req, set timeout_err (sticky until reset), return to IDLE, and leave the address unchanged.
REQ-022 Without FB_REQ_TIMEOUT_EN SHALL wait indefinitely for ack, with timeout_err tied to 0 and no counter logic.

Verification
REQ-023 Reset release, init_end=0, wr_level=100 -> no req; init_end=1 -> sdram_wr_req=1 with addr 0 and len 64 within 2 cycles.
REQ-024 Write burst, ack high 64 cycles -> req drops the cycle after the first ack; on ack fall addr=64, busy=0.
REQ-025 wr_level=100, rd_enable=1, rd_space=512 held constant -> bursts alternate W,R,W,R, starting with write.
REQ-026 FRAME_WORDS=200, BURST_LEN=64 -> write lengths 64,64,64,8 at addrs 0,64,128,192, then addr wraps to 0.
REQ-027 wr_vsync pulse mid write burst at addr 128 -> burst completes, next write addr=0, not 192.
REQ-028 FB_REQ_TIMEOUT_EN defined, TIMEOUT=255, no ack -> req drops after 255 cycles, timeout_err=1, addr unchanged.
